// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared types and helper functions for the multi-bus voice mixer
package mixer_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    SCALE = 2'd2
  } mix_state_e;

  // Accumulator width: one guard bit on top of the voice-count growth.
  function automatic int acc_w_f(input int data_w, input int n_voices);
    return data_w + $clog2(n_voices) + 1;
  endfunction

  // round(256*n/(n+2)) in Q0.8; only ever evaluated at elaboration.
  function automatic logic [7:0] norm_lut_f(input int n);
    return 8'((512 * n + n + 2) / (2 * n + 4));
  endfunction

  function automatic logic signed [63:0] sat_f(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/mixer_scaler.sv
// rtl/mixer_scaler.sv - two-stage volume / normalise / saturate datapath for one bus
module mixer_scaler
  import mixer_pkg::*;
#(
  parameter int ACC_W   = 30,
  parameter int DATA_W  = 24,
  parameter int VOL_W   = 16,
  parameter int NORM_EN = 1
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     c0_en,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [VOL_W-1:0]  vol,
  input  logic        [7:0]        norm,
  output logic signed [DATA_W-1:0] result
);

  localparam int P_W = ACC_W + VOL_W;
  localparam int Q_W = P_W + 9;

  logic signed [P_W-1:0] t_q;
  logic signed [Q_W-1:0] q_full;
  logic signed [Q_W-1:0] q_sel;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      t_q <= '0;
    end else if (c0_en) begin
      t_q <= (P_W'(acc) * P_W'(vol)) >>> 8;
    end
  end

  // Second cycle is combinational; the caller registers it into its shadow slot.
  assign q_full = Q_W'(t_q) * Q_W'($signed({1'b0, norm}));
  assign q_sel  = (NORM_EN != 0) ? (q_full >>> 8) : Q_W'(t_q);
  assign result = DATA_W'(sat_f(64'(q_sel), DATA_W));

endmodule

// File: rtl/voice_mixer_mc.sv
// rtl/voice_mixer_mc.sv - per-voice gain, multi-bus routing and frame-end scaling mixer
module voice_mixer_mc
  import mixer_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int N_VOICES = 32,
  parameter int N_OUT    = 2,
  parameter int GAIN_W   = 9,
  parameter int VOL_W    = 16,
  parameter int NORM_EN  = 1
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      frame_end,
  input  logic                      voice_valid,
  input  logic signed [DATA_W-1:0]  voice_sample,
  input  logic        [GAIN_W-1:0]  voice_gain,
  input  logic        [N_OUT-1:0]   voice_mask,
  input  logic signed [VOL_W-1:0]   master_volume,
  output logic [N_OUT*DATA_W-1:0]   mix_out,
  output logic                      mix_valid,
  output logic                      overrun,
  output logic                      busy
);

  localparam int ACC_W  = acc_w_f(DATA_W, N_VOICES);
  localparam int CNT_W  = $clog2(N_VOICES + 1);
  localparam int BI_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [CNT_W-1:0] N_MAX    = CNT_W'(N_VOICES);
  localparam logic [BI_W-1:0]  LAST_BUS = BI_W'(N_OUT - 1);

  mix_state_e                state;
  logic [BI_W-1:0]           bus_idx;
  logic                      phase;
  logic signed [DATA_W+1:0]  prod_q;
  logic                      prod_v;
  logic [N_OUT-1:0]          prod_mask;
  logic signed [ACC_W-1:0]   acc [N_OUT];
  logic [CNT_W-1:0]          n_active;
  logic signed [VOL_W-1:0]   vol_q;
  logic signed [DATA_W-1:0]  shadow [N_OUT];
  logic [7:0]                norm_lut [N_VOICES+1];
  logic signed [DATA_W-1:0]  scaled;
  logic [N_OUT*DATA_W-1:0]   mix_next;
  logic signed [PROD_W-1:0]  prod_full;

  for (genvar i = 0; i <= N_VOICES; i++) begin : g_lut
    assign norm_lut[i] = norm_lut_f(i);
  end

  logic in_accum, close_frame, open_frame, full, accept, drop, late_ctrl;
  assign in_accum    = (state == ACCUM);
  assign busy        = !in_accum;
  assign close_frame = in_accum && frame_end;
  // A frame_start coinciding with frame_end is dropped; the auto-clear covers it.
  assign open_frame  = in_accum && frame_start && !frame_end;
  assign full        = (n_active == N_MAX);
  assign accept      = in_accum && voice_valid && (open_frame || !full);
  assign drop        = voice_valid && !accept;
  assign late_ctrl   = !in_accum && (frame_start || frame_end);

  assign prod_full = PROD_W'(voice_sample) * PROD_W'($signed({1'b0, voice_gain}));

  mixer_scaler #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .VOL_W  (VOL_W),
    .NORM_EN(NORM_EN)
  ) u_scaler (
    .sys_clk(sys_clk),
    .rst    (rst),
    .c0_en  ((state == SCALE) && !phase),
    .acc    (acc[bus_idx]),
    .vol    (vol_q),
    .norm   (norm_lut[n_active]),
    .result (scaled)
  );

  // The last bus bypasses its shadow slot so every bus lands in the same cycle.
  always_comb begin
    mix_next = '0;
    for (int k = 0; k < N_OUT; k++) mix_next[k*DATA_W +: DATA_W] = shadow[k];
    mix_next[(N_OUT-1)*DATA_W +: DATA_W] = scaled;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= ACCUM;
      bus_idx   <= '0;
      phase     <= 1'b0;
      prod_q    <= '0;
      prod_v    <= 1'b0;
      prod_mask <= '0;
      n_active  <= '0;
      vol_q     <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        acc[k]    <= '0;
        shadow[k] <= '0;
      end
    end else begin
      mix_valid <= 1'b0;
      prod_v    <= accept;
      if (accept) begin
        prod_q    <= (DATA_W+2)'(prod_full >>> (GAIN_W - 1));
        prod_mask <= voice_mask;
      end
      if (drop || late_ctrl) overrun <= 1'b1;

      case (state)
        ACCUM: begin
          if (close_frame) begin
            state <= DRAIN;
            vol_q <= master_volume;
          end
          if (open_frame) begin
            for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
            n_active <= accept ? CNT_W'(1) : '0;
          end else begin
            for (int k = 0; k < N_OUT; k++)
              if (prod_v && prod_mask[k]) acc[k] <= acc[k] + ACC_W'(prod_q);
            if (accept) n_active <= n_active + CNT_W'(1);
          end
        end
        DRAIN: begin
          for (int k = 0; k < N_OUT; k++)
            if (prod_v && prod_mask[k]) acc[k] <= acc[k] + ACC_W'(prod_q);
          state   <= SCALE;
          bus_idx <= '0;
          phase   <= 1'b0;
        end
        SCALE: begin
          phase <= !phase;
          if (phase) begin
            shadow[bus_idx] <= scaled;
            bus_idx         <= bus_idx + BI_W'(1);
            if (bus_idx == LAST_BUS) begin
              mix_out   <= mix_next;
              mix_valid <= 1'b1;
              state     <= ACCUM;
              n_active  <= '0;
              for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
